// File: rtl/inst_fetch_resp_pkg.sv
// Shared bus widths, the default NOP and the fetch FSM state encoding for the
// instruction fetch responder.
package inst_fetch_resp_pkg;
    localparam int INST_ADDR_BUS = 32;
    localparam int REG_BUS       = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FLUSH = 3'd3,
        S_HOLD  = 3'd4
    } fetch_state_t;
endpackage

// File: rtl/inst_fetch_resp_timeout_cnt.sv
// Response timeout counter: cleared outside the waiting states, counts while
// enabled and flags expiry in the cycle its count reaches TIMEOUT.
module fetch_timeout_cnt #(
    parameter int TIMEOUT = 255,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == CNT_W'(TIMEOUT));
endmodule

// File: rtl/inst_fetch_resp.sv
// Fetch responder: one instruction-bus transaction per PC, delivers the word to
// IF/ID, stalls the PC while busy and discards fetches overtaken by a branch.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int ADDR_W  = INST_ADDR_BUS,
    parameter int DATA_W  = REG_BUS,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              branch_flag_i,
    input  logic [4:0]        stalled,
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [DATA_W-1:0] ibus_rdata_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    output logic              stallreq_o,
    output logic              fetch_err_o,
    output fetch_state_t      o_dbg_state
);
    fetch_state_t      r_state;
    logic              r_drop;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_addr;
    logic              r_valid;
    logic              r_err;

    logic w_waiting;
    logic w_timeout;
    logic w_deliver;
    logic w_stallreq;
    logic w_unused_stall;

    // Only the IF/ID hold bit of the stall vector matters to the fetch side.
    assign w_unused_stall = ^{stalled[4:2], stalled[0]};

    assign w_waiting = (r_state == S_WAIT) || (r_state == S_FLUSH);
    assign w_deliver = ibus_rvalid_i && !branch_flag_i;

    fetch_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (!w_waiting),
        .i_en     (w_waiting),
        .o_expire (w_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_drop      <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_inst      <= NOP_INST;
            r_inst_addr <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ce_i && !branch_flag_i) begin
                        r_addr  <= pc_i;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A granted request cannot be recalled, so a redirect only marks it for discard.
                    if (branch_flag_i) r_drop <= 1'b1;
                    if (ibus_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= (r_drop || branch_flag_i) ? S_FLUSH : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ibus_rvalid_i) begin
                        if (!branch_flag_i) begin
                            r_inst      <= ibus_rdata_i;
                            r_inst_addr <= r_addr;
                            r_valid     <= 1'b1;
                            r_state     <= stalled[1] ? S_HOLD : S_IDLE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        if (!branch_flag_i) begin
                            r_inst      <= NOP_INST;
                            r_inst_addr <= r_addr;
                            r_valid     <= 1'b1;
                        end
                    end else if (branch_flag_i) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (ibus_rvalid_i || w_timeout) begin
                        r_err   <= !ibus_rvalid_i;
                        r_drop  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (branch_flag_i) begin
                        r_state <= S_IDLE;
                    end else if (stalled[1]) begin
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Low only when a word is delivered or held, so the PC steps once per instruction.
    always_comb begin
        w_stallreq = 1'b0;
        case (r_state)
            S_IDLE:  w_stallreq = ce_i && !branch_flag_i;
            S_REQ:   w_stallreq = 1'b1;
            S_FLUSH: w_stallreq = 1'b1;
            S_WAIT:  w_stallreq = !w_deliver;
            default: w_stallreq = 1'b0;
        endcase
    end

    assign ibus_req_o   = r_req;
    assign ibus_addr_o  = r_addr;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_valid_o = r_valid;
    assign stallreq_o   = w_stallreq;
    assign fetch_err_o  = r_err;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp: deliveries are checked by a scoreboard
// monitor, handshake/stall/timeout behaviour by inline checks.
module tb_inst_fetch_resp;
    import inst_fetch_resp_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_i;
    logic          ce_i;
    logic          branch_flag_i;
    logic [4:0]    stalled;
    logic          ibus_req_o;
    logic [AW-1:0] ibus_addr_o;
    logic          ibus_gnt_i;
    logic          ibus_rvalid_i;
    logic [DW-1:0] ibus_rdata_i;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_addr_o;
    logic          inst_valid_o;
    logic          stallreq_o;
    logic          fetch_err_o;
    fetch_state_t  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_resp dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .branch_flag_i (branch_flag_i),
        .stalled       (stalled),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o),
        .stallreq_o    (stallreq_o),
        .fetch_err_o   (fetch_err_o),
        .o_dbg_state   (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, return at the falling edge.
    task automatic cyc(input logic ce, input logic [31:0] pc, input logic br, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic st);
        @(posedge clk);
        #1;
        ce_i          = ce;
        pc_i          = pc;
        branch_flag_i = br;
        ibus_gnt_i    = gnt;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rd;
        stalled       = {3'b000, st, 1'b0};
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Scoreboard monitor: each new delivery pops one expected {addr, inst}.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (inst_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got addr %0h inst %0h, expected no delivery",
                             inst_addr_o, inst_o);
                end else begin
                    check("delivery", 64'({inst_addr_o, inst_o}), 64'(exp_q.pop_front()));
                end
            end
            prev_valid = inst_valid_o;
        end
    end

    initial begin
        int err_seen;
        int stall_low;
        rst = 1'b1; ce_i = 1'b0; pc_i = '0; branch_flag_i = 1'b0; stalled = '0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 64'(ibus_req_o), 64'd0);
        check("rst_inst", 64'(inst_o), 64'(NOP));
        check("rst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset asserted while waiting for data at 0x80
        cyc(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t1_req", 64'(ibus_req_o), 64'd1);
        check("t1_addr", 64'(ibus_addr_o), 64'h80);
        cyc(1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t1_wait_state", 64'(dbg_state), 64'(S_WAIT));
        rst = 1'b1;
        #1;
        check("t1_rst_req", 64'(ibus_req_o), 64'd0);
        check("t1_rst_addr", 64'(ibus_addr_o), 64'd0);
        check("t1_rst_inst", 64'(inst_o), 64'(NOP));
        check("t1_rst_iaddr", 64'(inst_addr_o), 64'd0);
        check("t1_rst_valid", 64'(inst_valid_o), 64'd0);
        check("t1_rst_err", 64'(fetch_err_o), 64'd0);
        check("t1_rst_state", 64'(dbg_state), 64'(S_IDLE));
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0);
        idle_cyc();
        check("t1_late_valid", 64'(inst_valid_o), 64'd0);

        // Zero-wait fetch at 0x0
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t2_stall_idle", 64'(stallreq_o), 64'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t2_req", 64'(ibus_req_o), 64'd1);
        check("t2_stall_req", 64'(stallreq_o), 64'd1);
        exp_q.push_back({32'h0, 32'h0050_0093});
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0050_0093, 1'b0);
        check("t2_stall_rvalid", 64'(stallreq_o), 64'd0);
        check("t2_req_low", 64'(ibus_req_o), 64'd0);
        idle_cyc();
        check("t2_valid", 64'(inst_valid_o), 64'd1);
        idle_cyc();
        check("t2_valid_drop", 64'(inst_valid_o), 64'd0);

        // Grant delayed four cycles at 0x100
        cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h100, 1'b0, (i == 4), 1'b0, 32'h0, 1'b0);
            check($sformatf("t3_req_%0d", i), 64'(ibus_req_o), 64'd1);
            check($sformatf("t3_addr_%0d", i), 64'(ibus_addr_o), 64'h100);
            check($sformatf("t3_stall_%0d", i), 64'(stallreq_o), 64'd1);
        end
        exp_q.push_back({32'h100, 32'h00A0_0113});
        cyc(1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h00A0_0113, 1'b0);
        idle_cyc();
        idle_cyc();

        // Branch while waiting at 0x104; stale data discarded, refetch at 0x200
        cyc(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_stall_branch", 64'(stallreq_o), 64'd1);
        cyc(1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_flush_state", 64'(dbg_state), 64'(S_FLUSH));
        check("t4_flush_stall", 64'(stallreq_o), 64'd1);
        cyc(1'b0, 32'h200, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        idle_cyc();
        check("t4_no_valid", 64'(inst_valid_o), 64'd0);
        check("t4_idle", 64'(dbg_state), 64'(S_IDLE));
        cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t4_new_addr", 64'(ibus_addr_o), 64'h200);
        exp_q.push_back({32'h200, 32'h0000_0073});
        cyc(1'b0, 32'h200, 1'b0, 1'b0, 1'b1, 32'h0000_0073, 1'b0);
        idle_cyc();
        idle_cyc();

        // IF/ID held on delivery of 0x08
        cyc(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        exp_q.push_back({32'h8, 32'h0020_8193});
        cyc(1'b0, 32'h8, 1'b0, 1'b0, 1'b1, 32'h0020_8193, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, (i < 3));
            check($sformatf("t5_valid_%0d", i), 64'(inst_valid_o), 64'd1);
            check($sformatf("t5_inst_%0d", i), 64'(inst_o), 64'h0020_8193);
            check($sformatf("t5_iaddr_%0d", i), 64'(inst_addr_o), 64'h8);
            check($sformatf("t5_req_%0d", i), 64'(ibus_req_o), 64'd0);
            check($sformatf("t5_state_%0d", i), 64'(dbg_state), 64'(S_HOLD));
        end
        cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t5_release_valid", 64'(inst_valid_o), 64'd0);
        check("t5_release_stall", 64'(stallreq_o), 64'd1);

        // No response at 0x0C: timeout delivers NOP and pulses the error once
        cyc(1'b0, 32'hC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t6_req", 64'(ibus_req_o), 64'd1);
        check("t6_addr", 64'(ibus_addr_o), 64'hC);
        err_seen  = 0;
        stall_low = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) exp_q.push_back({32'hC, NOP});
            idle_cyc();
            if (fetch_err_o) err_seen++;
            if (!stallreq_o) stall_low++;
        end
        check("t6_err_early", 64'(err_seen), 64'd0);
        check("t6_stall_wait", 64'(stall_low), 64'd0);
        idle_cyc();
        check("t6_err_pulse", 64'(fetch_err_o), 64'd1);
        check("t6_valid", 64'(inst_valid_o), 64'd1);
        check("t6_state", 64'(dbg_state), 64'(S_IDLE));
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        check("t6_err_once", 64'(fetch_err_o), 64'd0);
        idle_cyc();
        check("t6_late_valid", 64'(inst_valid_o), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
- Responder side of the PC/fetch-enable interface: consumes pc_i/ce_i from the PC register and runs one instruction-bus transaction per PC.
- Returns the instruction and its address to the IF/ID stage.
- Holds the PC via a stall request while a fetch is outstanding.
- Discards in-flight fetches on branch redirect; a timeout counter protects against a hung bus.

Parameters:
- ADDR_W, 32, instruction address width (matches InstAddrBus)
- DATA_W, 32, instruction width (matches RegBus)
- TIMEOUT, 255, max cycles waiting for rvalid before error; counter width is clog2(TIMEOUT+1)
- NOP_INST, 32'h00000013, instruction emitted at reset and on timeout

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- pc_i  in  ADDR_W  fetch address from PC register
- ce_i  in  1  fetch enable from PC register
- branch_flag_i  in  1  redirect this cycle; PC reloads next edge
- stalled  in  5  pipeline stall vector; stalled[1] = IF/ID hold
- ibus_req_o  out  1  bus request
- ibus_addr_o  out  ADDR_W  bus address
- ibus_gnt_i  in  1  request accepted this cycle
- ibus_rvalid_i  in  1  read data valid
- ibus_rdata_i  in  DATA_W  read data
- inst_o  out  DATA_W  fetched instruction
- inst_addr_o  out  ADDR_W  address of inst_o
- inst_valid_o  out  1  inst_o is valid for IF/ID
- stallreq_o  out  1  combinational stall request to pipeline control (holds PC)
- fetch_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, immediate): state IDLE, drop_q=0, timer=0, ibus_req_o=0, ibus_addr_o=0, inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0, fetch_err_o=0.
- At most one outstanding transaction. ibus_req_o is registered (high exactly in REQ). ibus_addr_o = addr_q.
- IDLE:
  - ce_i=1 and branch_flag_i=0: addr_q<=pc_i, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Request held until ibus_gnt_i=1; it is never withdrawn.
  - branch_flag_i=1 sets drop_q.
  - On gnt: go to FLUSH if drop_q or branch_flag_i, else go to WAIT. Clear timer.
- WAIT:
  - rvalid with branch_flag_i=1: discard, go to IDLE.
  - rvalid with branch_flag_i=0: inst_o<=rdata, inst_addr_o<=addr_q, inst_valid_o<=1. Then go to HOLD if stalled[1]=1, else go to IDLE.
  - branch_flag_i=1 without rvalid: go to FLUSH.
- FLUSH: rvalid, discard, go to IDLE, clear drop_q.
- Timeout: timer increments each cycle in WAIT/FLUSH. At timer==TIMEOUT without rvalid:
  - fetch_err_o=1 for one cycle, go to IDLE.
  - In WAIT only: inst_o<=NOP_INST, inst_addr_o<=addr_q, inst_valid_o<=1.
  - A late rvalid arriving in IDLE is ignored.
- HOLD: output registers frozen. When stalled[1]=0, go to IDLE.
- inst_valid_o clears at the next edge after delivery unless state is HOLD. branch_flag_i=1 in any state clears inst_valid_o at the next edge; it has priority over HOLD and goes to IDLE.
- stallreq_o=1 when any of:
  - IDLE with ce_i and not branch;
  - REQ or FLUSH;
  - WAIT and not (rvalid and not branch).
  - It is low in the rvalid-delivery cycle and in HOLD, so the PC advances exactly once per delivered instruction.
- Best case: 1 IDLE + 1 REQ (gnt same cycle) + 1 WAIT (rvalid) = 3 cycles per instruction. inst_valid_o is high the cycle after rvalid.
- Address arithmetic is none: addresses pass through unchanged; wrap-around is owned by the PC register.

Decomposition:
- Shared defines file: state encodings (IDLE/REQ/WAIT/FLUSH/HOLD, 3 bits), NOP_INST, bus widths via existing InstAddrBus/RegBus.
- One natural sub-module: fetch_timeout_cnt (clear/enable/expire counter).
- FSM, output registers and stallreq logic stay in the top.

Test Plan:
- Reset mid-WAIT (addr 0x80) → all outputs reset values immediately; a late rvalid after reset produces no inst_valid_o.
- Gnt and rvalid with zero wait, pc_i=0x00000000, rdata=0x00500093 → inst_valid_o=1, inst_o=0x00500093, inst_addr_o=0x0 three edges after ce_i; stallreq_o low only on the rvalid cycle.
- Gnt delayed 4 cycles, pc_i=0x100 → ibus_req_o held with addr 0x100 for 5 cycles; stallreq_o high throughout; a single delivery with inst_addr_o=0x100.
- branch_flag_i pulsed in WAIT (addr 0x104), rvalid 2 cycles later with 0xDEADBEEF → no inst_valid_o; next fetch uses the new pc_i=0x200.
- stalled[1]=1 on delivery of addr 0x08 for 3 cycles → inst_valid_o, inst_o and inst_addr_o stable for 4 cycles; no new ibus_req_o until release.
- No rvalid for TIMEOUT=255 cycles at addr 0x0C → fetch_err_o pulses once; inst_o=0x00000013, inst_addr_o=0x0C, inst_valid_o=1.
